// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared types and sizing helper for the reset sequencer
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_POR = 2'd0,
        CAUSE_EXT = 2'd1,
        CAUSE_SW  = 2'd2
    } cause_t;

    // One spare bit above the largest count so the terminal value never wraps.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - board/SoC side signals of the reset sequencer
interface reset_sequencer_if #(
    parameter int N_CH = 2
);
    logic            ext_rst_n;
    logic            sw_rst_req;
    logic [N_CH-1:0] rst_n_out;
    logic            ready;
    logic [1:0]      rst_cause;

    modport master (
        output ext_rst_n,
        output sw_rst_req,
        input  rst_n_out,
        input  ready,
        input  rst_cause
    );

    modport slave (
        input  ext_rst_n,
        input  sw_rst_req,
        output rst_n_out,
        output ready,
        output rst_cause
    );
endinterface

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - button synchroniser and debounce, level request while held
module debounce_sync #(
    parameter int DEBOUNCE = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic ext_rst_n,
    output logic req
);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] D_MAX = DW'(DEBOUNCE);

    // Stored as "pressed" so an all-zero power-up state means button released.
    logic [1:0]    pressed_sync;
    logic [DW-1:0] low_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            pressed_sync <= 2'b00;
            low_cnt      <= '0;
        end else begin
            pressed_sync <= {pressed_sync[0], ~ext_rst_n};
            if (!pressed_sync[1]) begin
                low_cnt <= '0;
            end else if (low_cnt != D_MAX) begin
                low_cnt <= low_cnt + 1'b1;
            end
        end
    end

    assign req = pressed_sync[1] && (low_cnt == D_MAX);

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - power-on hold plus staggered multi-channel reset release
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int POR_CYCLES = 255,
    parameter int STAGGER    = 16,
    parameter int DEBOUNCE   = 1024
) (
    input logic             clk,
    input logic             rst,
    reset_sequencer_if.slave bus
);
    localparam int CNT_W = cnt_width(POR_CYCLES, (N_CH - 1) * STAGGER + 1, DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] POR_LAST = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_REL = CNT_W'((N_CH - 1) * STAGGER);

    // Every register's all-zero value is its reset value, so power-up is safe with rst tied low.
    state_t          state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [N_CH-1:0] rst_n_q, rst_n_next;
    logic            ready_q, ready_next;
    cause_t          cause_q, cause_next;
    logic            btn_req;

    debounce_sync #(.DEBOUNCE(DEBOUNCE)) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .ext_rst_n (bus.ext_rst_n),
        .req       (btn_req)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= HOLD;
            cnt     <= '0;
            rst_n_q <= '0;
            ready_q <= 1'b0;
            cause_q <= CAUSE_POR;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            rst_n_q <= rst_n_next;
            ready_q <= ready_next;
            cause_q <= cause_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        rst_n_next = rst_n_q;
        ready_next = ready_q;
        cause_next = cause_q;
        if (btn_req || bus.sw_rst_req) begin
            state_next = HOLD;
            cnt_next   = '0;
            rst_n_next = '0;
            ready_next = 1'b0;
            if (btn_req) cause_next = CAUSE_EXT;
            else         cause_next = CAUSE_SW;
        end else begin
            unique case (state)
                HOLD: begin
                    if (cnt == POR_LAST) begin
                        rst_n_next[0] = 1'b1;
                        if (N_CH == 1) begin
                            state_next = RUN;
                            ready_next = 1'b1;
                        end else begin
                            state_next = RELEASE;
                            // Count 1 on the edge after channel 0, so channel k matches at k*STAGGER.
                            cnt_next   = CNT_W'(1);
                        end
                    end else if (cnt != CNT_MAX) begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    for (int k = 1; k < N_CH; k++) begin
                        if (cnt == CNT_W'(k * STAGGER)) rst_n_next[k] = 1'b1;
                    end
                    if (cnt == LAST_REL) begin
                        state_next = RUN;
                        ready_next = 1'b1;
                    end else if (cnt != CNT_MAX) begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                RUN: begin
                end
                default: state_next = HOLD;
            endcase
        end
    end

    assign bus.rst_n_out = rst_n_q;
    assign bus.ready     = ready_q;
    assign bus.rst_cause = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - scoreboard bench: expected output changes queued by stimulus, checked by monitor
module tb_reset_sequencer;

    typedef struct {
        int         cyc;
        logic [2:0] rn;
        logic       rdy;
        logic [1:0] cause;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    reset_sequencer_if #(.N_CH(3)) bus_a ();
    reset_sequencer_if #(.N_CH(1)) bus_b ();

    reset_sequencer #(.N_CH(3), .POR_CYCLES(8), .STAGGER(4), .DEBOUNCE(5)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    reset_sequencer #(.N_CH(1), .POR_CYCLES(1), .STAGGER(4), .DEBOUNCE(5)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_a(input int c, input logic [2:0] rn, input logic rdy, input logic [1:0] cause);
        q_a.push_back('{cyc: c, rn: rn, rdy: rdy, cause: cause});
    endtask

    task automatic expect_b(input int c, input logic rn, input logic rdy, input logic [1:0] cause);
        q_b.push_back('{cyc: c, rn: {2'b00, rn}, rdy: rdy, cause: cause});
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic check_evt(input string nm, input bit have_exp, input exp_t e,
                             input logic [2:0] rn, input logic rdy, input logic [1:0] cause);
        n_total++;
        if (!have_exp)
            $display("FAIL %s unexpected change at cycle %0d: rst_n_out=%b ready=%b rst_cause=%0d, required no change",
                     nm, cyc, rn, rdy, cause);
        else if (e.cyc != cyc || e.rn !== rn || e.rdy !== rdy || e.cause !== cause)
            $display("FAIL %s got cycle %0d rst_n_out=%b ready=%b rst_cause=%0d, required cycle %0d rst_n_out=%b ready=%b rst_cause=%0d",
                     nm, cyc, rn, rdy, cause, e.cyc, e.rn, e.rdy, e.cause);
        else
            n_pass++;
    endtask

    logic [5:0] cur_a, prev_a, cur_b, prev_b;
    bit         have_a = 1'b0, have_b = 1'b0, hx;
    exp_t       e;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            cur_a = {bus_a.rst_n_out, bus_a.ready, bus_a.rst_cause};
            if (!have_a || cur_a != prev_a) begin
                e  = '{default: 0};
                hx = (q_a.size() != 0);
                if (hx) e = q_a.pop_front();
                check_evt("dut_a", hx, e, bus_a.rst_n_out, bus_a.ready, bus_a.rst_cause);
                prev_a = cur_a;
                have_a = 1'b1;
            end
            cur_b = {2'b00, bus_b.rst_n_out, bus_b.ready, bus_b.rst_cause};
            if (!have_b || cur_b != prev_b) begin
                e  = '{default: 0};
                hx = (q_b.size() != 0);
                if (hx) e = q_b.pop_front();
                check_evt("dut_b", hx, e, {2'b00, bus_b.rst_n_out}, bus_b.ready, bus_b.rst_cause);
                prev_b = cur_b;
                have_b = 1'b1;
            end
        end
    end

    initial begin
        bus_a.ext_rst_n  = 1'b1;
        bus_a.sw_rst_req = 1'b0;
        bus_b.ext_rst_n  = 1'b1;
        bus_b.sw_rst_req = 1'b0;
        expect_a(1, 3'b000, 1'b0, 2'd0);
        expect_b(1, 1'b0, 1'b0, 2'd0);

        // Power-on: rst sampled high at edges 1..3, low from E0 = 4.
        wait_to(3);
        rst = 1'b0;
        expect_b(4, 1'b1, 1'b1, 2'd0);
        expect_a(11, 3'b001, 1'b0, 2'd0);
        expect_a(15, 3'b011, 1'b0, 2'd0);
        expect_a(19, 3'b111, 1'b1, 2'd0);

        // Software reset from RUN, taken at E = 23.
        wait_to(22);
        bus_a.sw_rst_req = 1'b1;
        expect_a(23, 3'b000, 1'b0, 2'd2);
        expect_a(31, 3'b001, 1'b0, 2'd2);
        expect_a(35, 3'b011, 1'b0, 2'd2);
        expect_a(39, 3'b111, 1'b1, 2'd2);
        wait_to(23);
        bus_a.sw_rst_req = 1'b0;

        // Software reset, then another one cycle after 011 appears.
        wait_to(42);
        bus_a.sw_rst_req = 1'b1;
        expect_a(43, 3'b000, 1'b0, 2'd2);
        expect_a(51, 3'b001, 1'b0, 2'd2);
        expect_a(55, 3'b011, 1'b0, 2'd2);
        wait_to(43);
        bus_a.sw_rst_req = 1'b0;
        wait_to(55);
        bus_a.sw_rst_req = 1'b1;
        expect_a(56, 3'b000, 1'b0, 2'd2);
        expect_a(64, 3'b001, 1'b0, 2'd2);
        expect_a(68, 3'b011, 1'b0, 2'd2);
        expect_a(72, 3'b111, 1'b1, 2'd2);
        wait_to(56);
        bus_a.sw_rst_req = 1'b0;

        // Bouncing button: 4 low, 1 high, 4 low never qualifies.
        wait_to(75); bus_a.ext_rst_n = 1'b0;
        wait_to(79); bus_a.ext_rst_n = 1'b1;
        wait_to(80); bus_a.ext_rst_n = 1'b0;
        wait_to(84); bus_a.ext_rst_n = 1'b1;

        // Long press: first low sample at 91, taken at 91+2+5 = 98; released at 101.
        wait_to(90);
        bus_a.ext_rst_n = 1'b0;
        expect_a(98, 3'b000, 1'b0, 2'd1);
        wait_to(100);
        bus_a.ext_rst_n = 1'b1;
        expect_a(110, 3'b001, 1'b0, 2'd1);
        expect_a(114, 3'b011, 1'b0, 2'd1);
        expect_a(118, 3'b111, 1'b1, 2'd1);

        // Button request and software request on the same edge (130): button wins.
        wait_to(122);
        bus_a.ext_rst_n = 1'b0;
        expect_a(130, 3'b000, 1'b0, 2'd1);
        wait_to(129);
        bus_a.sw_rst_req = 1'b1;
        wait_to(130);
        bus_a.sw_rst_req = 1'b0;
        bus_a.ext_rst_n  = 1'b1;
        expect_a(140, 3'b001, 1'b0, 2'd1);
        expect_a(144, 3'b011, 1'b0, 2'd1);
        expect_a(148, 3'b111, 1'b1, 2'd1);

        // rst and software request on the same edge (151): rst wins.
        wait_to(150);
        rst = 1'b1;
        bus_a.sw_rst_req = 1'b1;
        expect_a(151, 3'b000, 1'b0, 2'd0);
        expect_b(151, 1'b0, 1'b0, 2'd0);
        expect_b(152, 1'b1, 1'b1, 2'd0);
        wait_to(151);
        rst = 1'b0;
        bus_a.sw_rst_req = 1'b0;
        expect_a(159, 3'b001, 1'b0, 2'd0);
        expect_a(163, 3'b011, 1'b0, 2'd0);
        expect_a(167, 3'b111, 1'b1, 2'd0);

        wait_to(175);
        n_total++;
        if (q_a.size() == 0) n_pass++;
        else $display("FAIL dut_a pending events: %0d left, required 0, next due cycle %0d", q_a.size(), q_a[0].cyc);
        n_total++;
        if (q_b.size() == 0) n_pass++;
        else $display("FAIL dut_b pending events: %0d left, required 0, next due cycle %0d", q_b.size(), q_b[0].cyc);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised reset generator for the ECP5 SoC top level. It extends the fixed 8-bit power-on reset counter into a sequencer with several reset channels released in a fixed, staggered order. It accepts a debounced board button and a software reset request from the SoC, and records the cause of the last reset. It sits between the board clock/reset pins and the `cve2_soc` instance, plus any peripheral clusters that need later release.

## Interface
- `N_CH`, 2: number of reset channels (1..8); channel 0 is released first.
- `POR_CYCLES`, 255: hold length in cycles before channel 0 releases (>= 1).
- `STAGGER`, 16: cycles between consecutive channel releases (>= 1).
- `DEBOUNCE`, 1024: cycles the button must be stable low to count as a request (>= 1).
- `clk`  in  1  board clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `ext_rst_n`  in  1  board button, asynchronous, active-low.
- `sw_rst_req`  in  1  single-cycle software reset request from the SoC.
- `rst_n_out`  out  N_CH  per-channel resets, active-low; bit k drives domain k.
- `ready`  out  1  high when every channel is released.
- `rst_cause`  out  2  cause of last reset: 0 power-on/`rst`, 1 button, 2 software; 3 is unused.

## Operation
- FSM states:
  - HOLD: all `rst_n_out` = 0; the counter counts up to POR_CYCLES.
  - RELEASE: channels release one by one, with STAGGER cycles between them.
  - RUN: all channels released; `ready` = 1.
- Reset and initial state:
  - Bitstream initial values equal the reset values, so the block runs correctly with `rst` tied 0.
  - Reset values: state HOLD, counter 0, `rst_n_out` = 0, `ready` = 0, `rst_cause` = 0.
- Reset requests (`rst`, debounced button low, `sw_rst_req`) have the same effect in any state:
  - Next state is HOLD.
  - Counter clears.
  - All `rst_n_out` and `ready` go low at the following edge.
- A request that stays active (`rst` high, button still held) keeps the FSM in HOLD with the counter at 0. Counting starts on the first cycle the request is absent.
- HOLD -> RELEASE when the counter reaches POR_CYCLES-1 with no request active. At that edge `rst_n_out[0]` goes high.
- In RELEASE, `rst_n_out[k]` goes high exactly k*STAGGER cycles after `rst_n_out[0]`. Once a channel is released it stays high until the next request.
- The edge that releases channel N_CH-1 also moves the FSM to RUN and sets `ready`. With N_CH=1 the FSM goes from HOLD straight to RUN.
- Button path:
  - Two-flop synchroniser, then a debounce counter.
  - The request goes active when the synchronised level has been low for DEBOUNCE consecutive cycles.
  - The request clears on the first cycle the synchronised level is high.
  - Any high sample restarts the debounce count.
- Cause capture:
  - `rst_cause` updates on the edge where a request is taken.
  - Priority when requests coincide: `rst` (0) > button (1) > software (2).
  - The value holds until the next request.
- `sw_rst_req` while already in HOLD restarts the count and updates the cause.
- Counter width is `$clog2` of the maximum of POR_CYCLES, (N_CH-1)*STAGGER+1 and DEBOUNCE, plus 1. The counter never wraps; it saturates at its terminal value.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- `rst` sampled high at edge E: outputs low after edge E.
- `rst` sampled low from edge E0 onward:
  - `rst_n_out[0]` high after edge E0+POR_CYCLES-1.
  - `rst_n_out[k]` high after edge E0+POR_CYCLES-1+k*STAGGER.
- `sw_rst_req` sampled at edge E: outputs low after E; channel 0 high after E+POR_CYCLES.
- Button latency from pin to outputs going low: 2 synchroniser cycles + DEBOUNCE cycles + 1 cycle.

## Structure
- Package `reset_seq_pkg` holds:
  - the state enum (HOLD, RELEASE, RUN);
  - the cause encodings (CAUSE_POR, CAUSE_EXT, CAUSE_SW);
  - a `clog2`-max helper for the counter width.
- Sub-module `debounce_sync` (parameter DEBOUNCE) contains the synchroniser and debounce counter. It outputs a level request `req` that is active while the button is held and debounced.

## Test plan
Bench parameters for all scenarios: N_CH=3, POR_CYCLES=8, STAGGER=4, DEBOUNCE=5.

- Power-on: `rst` high 3 cycles, then low at E0 -> `rst_n_out` goes 001 at E0+7, 011 at E0+11, 111 at E0+15; `ready`=1 at E0+15; `rst_cause`=0.
- Software reset in RUN: pulse `sw_rst_req` at E -> `rst_n_out`=000 and `ready`=0 after E; 001 at E+8; 111 at E+16; `rst_cause`=2.
- Button bounce: `ext_rst_n` low 4 cycles, high 1, low 4 -> no reset. Low 5+ cycles -> reset taken; `rst_cause`=1; outputs held at 000 while the button stays low; release sequence restarts from the button going high.
- Reset mid-release: `sw_rst_req` one cycle after `rst_n_out`=011 -> 000 immediately; full 8/4/4 sequence restarts.
- Simultaneous `rst` and `sw_rst_req` -> `rst_cause`=0. Simultaneous button request and `sw_rst_req` -> `rst_cause`=1.
- N_CH=1, POR_CYCLES=1: `rst` low at E0 -> `rst_n_out`=1 and `ready`=1 after E0; FSM never enters RELEASE.
